// File: rtl/round_sequencer.sv
// -----------------------------------------------------------------------------
// round_sequencer
//   Round control for the low-throughput Keccak-f[1600] permutation core.
//   A start request launches a run that steps a one-hot round index through
//   rounds 0..ROUNDS-1, advancing once per step_en from the datapath, and then
//   pulses done for one cycle. Outside a run the index is all-zero, so the
//   round-constant lookup driven by round_onehot yields a zero constant.
//
// Parameters
//   ROUNDS  rounds per permutation (1..24; <24 only for reduced-round builds)
//   CNT_W   width of round_num; 2**CNT_W >= ROUNDS
//
// Ports
//   clk           in   rising-edge clock
//   reset         in   asynchronous active-high reset, clears all state
//   start         in   permutation request, sampled only in IDLE
//   step_en       in   datapath retires the current round at this edge
//   abort         in   cancel the run, back to IDLE without done
//   round_onehot  out  [23:0] one-hot round index (bits >= ROUNDS always 0)
//   round_num     out  [CNT_W-1:0] binary index of the active round
//   first_round   out  RUN and round_num == 0
//   last_round    out  RUN and round_num == ROUNDS-1
//   busy          out  state is RUN
//   done          out  one-cycle pulse after the final round retires
//   state_dbg     out  [1:0] raw FSM state (0 IDLE, 1 RUN, 2 DONE)
//
// Handshake: start, step_en and abort are level-sampled qualifiers, not a
//   valid/ready pair. start is acted on only at an IDLE edge (never queued);
//   step_en is acted on only at a RUN edge; abort wins over both in any state.
//   Every output comes from registers, so none depends on this cycle's inputs.
// -----------------------------------------------------------------------------
module round_sequencer #(
    parameter int ROUNDS = 24,
    parameter int CNT_W  = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             step_en,
    input  logic             abort,
    output logic [23:0]      round_onehot,
    output logic [CNT_W-1:0] round_num,
    output logic             first_round,
    output logic             last_round,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_NUM = CNT_W'(ROUNDS - 1);

    state_t           state;
    state_t           state_nx;
    logic [23:0]      onehot_nx;
    logic [CNT_W-1:0] num_nx;

    // State register plus the round index registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            round_onehot <= 24'h0;
            round_num    <= '0;
        end else begin
            state        <= state_nx;
            round_onehot <= onehot_nx;
            round_num    <= num_nx;
        end
    end

    // Next-state and next-index logic. The index registers are cleared on
    // every transition out of RUN so that they read zero in IDLE and DONE.
    always_comb begin
        state_nx  = state;
        onehot_nx = round_onehot;
        num_nx    = round_num;
        if (abort) begin
            state_nx  = IDLE;
            onehot_nx = 24'h0;
            num_nx    = '0;
        end else begin
            case (state)
                IDLE: begin
                    onehot_nx = 24'h0;
                    num_nx    = '0;
                    if (start) begin
                        state_nx  = RUN;
                        onehot_nx = 24'h000001;
                    end
                end
                RUN: begin
                    if (step_en) begin
                        if (last_round) begin
                            state_nx  = DONE;
                            onehot_nx = 24'h0;
                            num_nx    = '0;
                        end else begin
                            // Never shifts past bit ROUNDS-1: the last round
                            // leaves RUN instead of shifting.
                            onehot_nx = {round_onehot[22:0], 1'b0};
                            num_nx    = round_num + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    state_nx  = IDLE;
                    onehot_nx = 24'h0;
                    num_nx    = '0;
                end
                default: begin
                    state_nx  = IDLE;
                    onehot_nx = 24'h0;
                    num_nx    = '0;
                end
            endcase
        end
    end

    // Outputs decoded from registered state only.
    always_comb begin
        busy        = (state == RUN);
        done        = (state == DONE);
        first_round = busy && (round_num == '0);
        last_round  = busy && (round_num == LAST_NUM);
        state_dbg   = state;
    end

endmodule
